pipeline_memory: RTL and testbench



---
 rtl/pipeline_memory.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_memory.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_memory.sv
// Memory stage: registers retiring execute results and runs LDR/STR over the dmem handshake.
// Optional watchdog enabled by defining PIPELINE_MEMORY_TIMEOUT_EN.
module pipeline_memory #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        execute_done,
    input  logic        execute_is_dependent,
    input  logic [15:0] execute_result,
    input  logic [15:0] execute_instr,
    input  logic [15:0] store_data,
    output logic [2:0]  store_reg_num,
    output logic        memory_busy,
    output logic        memory_done,
    output logic        memory_is_dependent,
    output logic [15:0] memory_result,
    output logic [15:0] memory_instr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [15:0] dmem_rdata,
    output logic        memory_fault
);

    localparam logic [3:0] OP_LDR = 4'b1000;
    localparam logic [3:0] OP_STR = 4'b1001;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_RDATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        dep_q, dep_d;
    logic [15:0] result_q, result_d;
    logic [15:0] instr_q, instr_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic        is_ldr_s;
    logic        is_str_s;
    logic        timeout_s;

    assign is_ldr_s = (execute_instr[15:12] == OP_LDR);
    assign is_str_s = (execute_instr[15:12] == OP_STR);

`ifdef PIPELINE_MEMORY_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);
    logic [7:0] cnt_q, cnt_d;

    // Expiry fires on the edge where the count would reach TIMEOUT_CYCLES.
    assign timeout_s = (state_q != IDLE) && (cnt_q == TMO_LAST);

    // Watchdog count: cleared on entry to a waiting state, advanced while staying there.
    always_comb begin
        cnt_d = 8'd0;
        if (state_d != IDLE && state_d == state_q) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic for the memory-stage FSM.
    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        dep_d    = dep_q;
        result_d = result_q;
        instr_d  = instr_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        fault_d  = fault_q;
        case (state_q)
            IDLE: begin
                instr_d = execute_instr;
                if (is_ldr_s || is_str_s) begin
                    done_d   = 1'b0;
                    dep_d    = is_ldr_s;
                    result_d = 16'h0000;
                    addr_d   = execute_result;
                    we_d     = is_str_s;
                    state_d  = REQ;
                    if (is_str_s) begin
                        wdata_d = store_data;
                    end else begin
                        wdata_d = wdata_q;
                    end
                end else begin
                    result_d = execute_result;
                    done_d   = execute_done;
                    dep_d    = execute_is_dependent;
                    state_d  = IDLE;
                end
            end
            REQ: begin
                // Stores finish on acceptance; loads still wait for read data.
                if (dmem_ready) begin
                    if (we_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_RDATA;
                    end
                end else if (timeout_s) begin
                    result_d = 16'hDEAD;
                    done_d   = 1'b1;
                    fault_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT_RDATA: begin
                if (dmem_rvalid) begin
                    result_d = dmem_rdata;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (timeout_s) begin
                    result_d = 16'hDEAD;
                    done_d   = 1'b1;
                    fault_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = WAIT_RDATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            dep_q    <= 1'b0;
            result_q <= 16'h0000;
            instr_q  <= 16'h0000;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            dep_q    <= dep_d;
            result_q <= result_d;
            instr_q  <= instr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fault_q  <= fault_d;
        end
    end

    // Request is decoded from state alone so dmem_ready never loops back into it.
    assign store_reg_num       = execute_instr[2:0];
    assign memory_busy         = (state_q != IDLE);
    assign dmem_req            = (state_q == REQ);
    assign memory_done         = done_q;
    assign memory_is_dependent = dep_q;
    assign memory_result       = result_q;
    assign memory_instr        = instr_q;
    assign dmem_we             = we_q;
    assign dmem_addr           = addr_q;
    assign dmem_wdata          = wdata_q;
    assign memory_fault        = fault_q;

endmodule

// File: tb/tb_pipeline_memory.sv
// Directed bench for pipeline_memory: reset, pass-through, LDR/STR handshakes, hold-off of upstream.
module tb_pipeline_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        execute_done;
    logic        execute_is_dependent;
    logic [15:0] execute_result;
    logic [15:0] execute_instr;
    logic [15:0] store_data;
    logic [2:0]  store_reg_num;
    logic        memory_busy;
    logic        memory_done;
    logic        memory_is_dependent;
    logic [15:0] memory_result;
    logic [15:0] memory_instr;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [15:0] dmem_rdata;
    logic        memory_fault;

    int checks = 0;
    int errors = 0;

    pipeline_memory #(.TIMEOUT_CYCLES(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .execute_done         (execute_done),
        .execute_is_dependent (execute_is_dependent),
        .execute_result       (execute_result),
        .execute_instr        (execute_instr),
        .store_data           (store_data),
        .store_reg_num        (store_reg_num),
        .memory_busy          (memory_busy),
        .memory_done          (memory_done),
        .memory_is_dependent  (memory_is_dependent),
        .memory_result        (memory_result),
        .memory_instr         (memory_instr),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_ready           (dmem_ready),
        .dmem_rvalid          (dmem_rvalid),
        .dmem_rdata           (dmem_rdata),
        .memory_fault         (memory_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_exec(input logic [15:0] instr, input logic [15:0] res,
                              input logic done, input logic dep);
        execute_instr        = instr;
        execute_result       = res;
        execute_done         = done;
        execute_is_dependent = dep;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   {15'd0, memory_busy}, 16'h0000);
        chk({tag, "_done"},   {15'd0, memory_done}, 16'h0000);
        chk({tag, "_dep"},    {15'd0, memory_is_dependent}, 16'h0000);
        chk({tag, "_result"}, memory_result, 16'h0000);
        chk({tag, "_instr"},  memory_instr, 16'h0000);
        chk({tag, "_req"},    {15'd0, dmem_req}, 16'h0000);
        chk({tag, "_we"},     {15'd0, dmem_we}, 16'h0000);
        chk({tag, "_addr"},   dmem_addr, 16'h0000);
        chk({tag, "_wdata"},  dmem_wdata, 16'h0000);
        chk({tag, "_fault"},  {15'd0, memory_fault}, 16'h0000);
    endtask

    initial begin
        reset       = 1'b0;
        drive_exec(16'h0000, 16'h0000, 1'b0, 1'b0);
        store_data  = 16'h0000;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 16'h0000;
        #1;
        chk_all_zero("por");
        tick();
        tick();
        reset = 1'b1;

        // ADD passes through in one cycle
        drive_exec(16'h1003, 16'h1234, 1'b1, 1'b1);
        #1;
        chk("add_store_reg_num", {13'd0, store_reg_num}, 16'h0003);
        tick();
        chk("add_result", memory_result, 16'h1234);
        chk("add_done", {15'd0, memory_done}, 16'h0001);
        chk("add_dep", {15'd0, memory_is_dependent}, 16'h0001);
        chk("add_busy", {15'd0, memory_busy}, 16'h0000);
        chk("add_instr", memory_instr, 16'h1003);

        // LDR with slow ready and slow rvalid; ADD waits upstream
        drive_exec(16'h8002, 16'h0040, 1'b0, 1'b1);
        #1;
        chk("ldr_store_reg_num", {13'd0, store_reg_num}, 16'h0002);
        tick();
        drive_exec(16'h1105, 16'h0777, 1'b1, 1'b1);
        chk("ldr_acc_busy", {15'd0, memory_busy}, 16'h0001);
        chk("ldr_acc_req", {15'd0, dmem_req}, 16'h0001);
        chk("ldr_acc_addr", dmem_addr, 16'h0040);
        chk("ldr_acc_we", {15'd0, dmem_we}, 16'h0000);
        chk("ldr_acc_done", {15'd0, memory_done}, 16'h0000);
        chk("ldr_acc_dep", {15'd0, memory_is_dependent}, 16'h0001);
        chk("ldr_acc_instr", memory_instr, 16'h8002);
        chk("ldr_acc_result", memory_result, 16'h0000);
        tick();
        chk("ldr_req1_req", {15'd0, dmem_req}, 16'h0001);
        chk("ldr_req1_instr", memory_instr, 16'h8002);
        tick();
        chk("ldr_req2_req", {15'd0, dmem_req}, 16'h0001);
        chk("ldr_req2_addr", dmem_addr, 16'h0040);
        chk("ldr_req2_we", {15'd0, dmem_we}, 16'h0000);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        chk("ldr_wait_req", {15'd0, dmem_req}, 16'h0000);
        chk("ldr_wait_busy", {15'd0, memory_busy}, 16'h0001);
        chk("ldr_wait_done", {15'd0, memory_done}, 16'h0000);
        tick();
        chk("ldr_wait1_done", {15'd0, memory_done}, 16'h0000);
        tick();
        chk("ldr_wait2_done", {15'd0, memory_done}, 16'h0000);
        chk("ldr_wait2_addr", dmem_addr, 16'h0040);
        chk("ldr_wait2_instr", memory_instr, 16'h8002);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 16'hBEEF;
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 16'h0000;
        chk("ldr_done_result", memory_result, 16'hBEEF);
        chk("ldr_done_done", {15'd0, memory_done}, 16'h0001);
        chk("ldr_done_busy", {15'd0, memory_busy}, 16'h0000);
        chk("ldr_done_instr", memory_instr, 16'h8002);
        tick();
        chk("held_add_instr", memory_instr, 16'h1105);
        chk("held_add_result", memory_result, 16'h0777);
        chk("held_add_done", {15'd0, memory_done}, 16'h0001);
        drive_exec(16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("after_add_instr", memory_instr, 16'h0000);

        // STR with ready tied high
        drive_exec(16'h9004, 16'h0010, 1'b0, 1'b0);
        store_data = 16'hA5A5;
        dmem_ready = 1'b1;
        #1;
        chk("str_store_reg_num", {13'd0, store_reg_num}, 16'h0004);
        tick();
        drive_exec(16'h0000, 16'h0000, 1'b0, 1'b0);
        store_data = 16'h0000;
        chk("str_acc_req", {15'd0, dmem_req}, 16'h0001);
        chk("str_acc_we", {15'd0, dmem_we}, 16'h0001);
        chk("str_acc_wdata", dmem_wdata, 16'hA5A5);
        chk("str_acc_addr", dmem_addr, 16'h0010);
        chk("str_acc_dep", {15'd0, memory_is_dependent}, 16'h0000);
        chk("str_acc_done", {15'd0, memory_done}, 16'h0000);
        tick();
        chk("str_t1_done", {15'd0, memory_done}, 16'h0001);
        chk("str_t1_busy", {15'd0, memory_busy}, 16'h0000);
        chk("str_t1_req", {15'd0, dmem_req}, 16'h0000);
        chk("str_t1_dep", {15'd0, memory_is_dependent}, 16'h0000);
        chk("str_t1_instr", memory_instr, 16'h9004);
        dmem_ready = 1'b0;
        tick();
        chk("str_next_done", {15'd0, memory_done}, 16'h0000);

        // Reset mid WAIT_RDATA, then stale rvalid
        drive_exec(16'h8001, 16'h0020, 1'b0, 1'b1);
        dmem_ready = 1'b1;
        tick();
        drive_exec(16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        dmem_ready = 1'b0;
        chk("rst_pre_busy", {15'd0, memory_busy}, 16'h0001);
        chk("rst_pre_req", {15'd0, dmem_req}, 16'h0000);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        reset = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 16'h5555;
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 16'h0000;
        chk_all_zero("rst_stale");

`ifdef PIPELINE_MEMORY_TIMEOUT_EN
        // Watchdog expiry with ready held low
        drive_exec(16'h8003, 16'h0050, 1'b0, 1'b1);
        tick();
        drive_exec(16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("tmo_wait_busy", {15'd0, memory_busy}, 16'h0001);
            chk("tmo_wait_fault", {15'd0, memory_fault}, 16'h0000);
        end
        tick();
        chk("tmo_fault", {15'd0, memory_fault}, 16'h0001);
        chk("tmo_result", memory_result, 16'hDEAD);
        chk("tmo_done", {15'd0, memory_done}, 16'h0001);
        chk("tmo_busy", {15'd0, memory_busy}, 16'h0000);
        tick();
        chk("tmo_sticky", {15'd0, memory_fault}, 16'h0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
